// File: rtl/fifo_stream_pkg.sv
// Shared widths and helpers for the FIFO-to-AXI-Stream drain path.
package fifo_stream_pkg;

  localparam int PKT_COUNT_W = 16;

  // Bits needed to index n distinct values; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w++;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_out_buffer.sv
// Small circular output buffer feeding the stream master; tvalid/tdata come
// straight from the buffer registers so the stream never sees raw FIFO data.
module stream_out_buffer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [DATA_WIDTH-1:0]             push_data,
  input  logic                              pop_ready,
  output logic [clog2_min1(DEPTH + 1)-1:0]  occ,
  output logic                              tvalid,
  output logic [DATA_WIDTH-1:0]             tdata
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int OCC_W = clog2_min1(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [OCC_W-1:0]      occ_reg, occ_next;
  logic                  pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign tvalid = (occ_reg != '0);
  assign pop    = tvalid & pop_ready;
  assign occ    = occ_reg;
  assign tdata  = tvalid ? mem_reg[rd_ptr_reg] : '0;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    occ_next    = occ_reg;
    if (push) begin
      wr_ptr_next = ptr_inc(wr_ptr_reg);
    end
    if (pop) begin
      rd_ptr_next = ptr_inc(rd_ptr_reg);
    end
    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      occ_reg    <= occ_next;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Upstream credit accounting must make a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !pop && (occ_reg == OCC_W'(DEPTH))));
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a fixed-latency FIFO read port into an AXI-Stream master with
// credit-based read issue and optional fixed-length tlast framing.
module fifo_axis_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int OBUF_DEPTH   = READ_LATENCY + 1,
  parameter int EMPTY_LAG    = 1,
  parameter int PKT_LEN      = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_empty,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic [PKT_COUNT_W-1:0] pkt_count
);

  localparam int   OCC_W  = clog2_min1(OBUF_DEPTH + 1);
  localparam logic LAG_EN = (EMPTY_LAG != 0);

  logic [READ_LATENCY-1:0] inflight_reg, inflight_next;
  logic [OCC_W-1:0]        inflight;
  logic [OCC_W-1:0]        occ;
  logic [OCC_W:0]          credit_sum;
  logic                    capture;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OCC_W'(inflight_reg[i]);
    end
  end

  // Every outstanding read already owns a buffer slot, so a capture always fits.
  // With a lagging empty flag, skip the cycle right after a strobe.
  assign credit_sum = {1'b0, occ} + {1'b0, inflight};
  assign fifo_rd_en = ~reset & ~fifo_empty
                    & (credit_sum < (OCC_W + 1)'(OBUF_DEPTH))
                    & ~(LAG_EN & inflight_reg[0]);

  assign inflight_next = (inflight_reg << 1) | READ_LATENCY'(fifo_rd_en);
  assign capture       = inflight_reg[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  stream_out_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (OBUF_DEPTH)
  ) u_obuf (
    .clk       (clk),
    .reset     (reset),
    .push      (capture & ~reset),
    .push_data (fifo_rd_data),
    .pop_ready (m_axis_tready),
    .occ       (occ),
    .tvalid    (m_axis_tvalid),
    .tdata     (m_axis_tdata)
  );

  assign busy = (occ != '0) | (inflight != '0);

  generate
    if (PKT_LEN > 0) begin : g_framing
      localparam int BEAT_W = clog2_min1(PKT_LEN);

      logic [BEAT_W-1:0]      beat_reg, beat_next;
      logic [PKT_COUNT_W-1:0] pkt_count_reg, pkt_count_next;
      logic                   handshake;
      logic                   last_beat;

      always_comb begin
        last_beat      = (beat_reg == BEAT_W'(PKT_LEN - 1));
        handshake      = m_axis_tvalid & m_axis_tready;
        beat_next      = beat_reg;
        pkt_count_next = pkt_count_reg;
        if (handshake) begin
          if (last_beat) begin
            beat_next      = '0;
            pkt_count_next = pkt_count_reg + PKT_COUNT_W'(1);
          end else begin
            beat_next = beat_reg + BEAT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          beat_reg      <= '0;
          pkt_count_reg <= '0;
        end else begin
          beat_reg      <= beat_next;
          pkt_count_reg <= pkt_count_next;
        end
      end

      assign m_axis_tlast = last_beat & m_axis_tvalid;
      assign pkt_count    = pkt_count_reg;
    end else begin : g_no_framing
      assign m_axis_tlast = 1'b0;
      assign pkt_count    = '0;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench: two readers (lagging empty + 4-beat packets, exact empty +
// no framing) drain identical FIFO models; a monitor checks every beat.
module tb_fifo_axis_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset  = 1'b1;
  logic        tready = 1'b1;

  logic        rd_en_a, rd_en_b;
  logic [31:0] rd_data_a = '0, rd_data_b = '0;
  logic        empty_a = 1'b1, empty_b = 1'b1;
  logic [31:0] tdata_a, tdata_b;
  logic        tvalid_a, tvalid_b, tlast_a, tlast_b, busy_a, busy_b;
  logic [15:0] pkt_a, pkt_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] mq_a[$], mq_b[$], pend_a[$], pend_b[$];
  logic [32:0] exp_a[$], exp_b[$];
  int          hs_a[$], hs_b[$];
  int          first_rd_a = -1, first_rd_b = -1;
  int          strobes_a = 0, strobes_b = 0;
  int          beat_a = 0;

  fifo_axis_reader #(
    .DATA_WIDTH(32), .READ_LATENCY(1), .OBUF_DEPTH(2), .EMPTY_LAG(1), .PKT_LEN(4)
  ) dut_a (
    .clk(clk), .reset(reset), .fifo_rd_en(rd_en_a), .fifo_rd_data(rd_data_a),
    .fifo_empty(empty_a), .m_axis_tdata(tdata_a), .m_axis_tvalid(tvalid_a),
    .m_axis_tready(tready), .m_axis_tlast(tlast_a), .busy(busy_a), .pkt_count(pkt_a)
  );

  fifo_axis_reader #(
    .DATA_WIDTH(32), .READ_LATENCY(1), .OBUF_DEPTH(3), .EMPTY_LAG(0), .PKT_LEN(0)
  ) dut_b (
    .clk(clk), .reset(reset), .fifo_rd_en(rd_en_b), .fifo_rd_data(rd_data_b),
    .fifo_empty(empty_b), .m_axis_tdata(tdata_b), .m_axis_tvalid(tvalid_b),
    .m_axis_tready(tready), .m_axis_tlast(tlast_b), .busy(busy_b), .pkt_count(pkt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model A: empty flag reflects the count from before the last edge.
  always @(posedge clk) begin
    int sz;
    if (reset) begin
      mq_a.delete();
      pend_a.delete();
      empty_a <= 1'b1;
    end else begin
      sz = mq_a.size();
      if (rd_en_a) begin
        strobes_a++;
        checks++;
        if (sz == 0) begin
          failures++;
          $display("FAIL strobe_a_underflow actual_count=0 required_count>0");
        end else begin
          rd_data_a <= mq_a.pop_front();
        end
      end
      while (pend_a.size() > 0) mq_a.push_back(pend_a.pop_front());
      empty_a <= (sz == 0);
    end
  end

  // FIFO model B: exact empty flag.
  always @(posedge clk) begin
    if (reset) begin
      mq_b.delete();
      pend_b.delete();
      empty_b <= 1'b1;
    end else begin
      if (rd_en_b) begin
        strobes_b++;
        checks++;
        if (mq_b.size() == 0) begin
          failures++;
          $display("FAIL strobe_b_underflow actual_count=0 required_count>0");
        end else begin
          rd_data_b <= mq_b.pop_front();
        end
      end
      while (pend_b.size() > 0) mq_b.push_back(pend_b.pop_front());
      empty_b <= (mq_b.size() == 0);
    end
  end

  // Monitors: pop the expected beat whenever a handshake is presented.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      if (rd_en_a && first_rd_a < 0) first_rd_a = cyc;
      if (tvalid_a && tready) begin
        hs_a.push_back(cyc);
        if (exp_a.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_a_unexpected actual=%0h required=none", tdata_a);
        end else begin
          e = exp_a.pop_front();
          check("beat_a_data", tdata_a, e[31:0]);
          check("beat_a_last", 32'(tlast_a), 32'(e[32]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset) begin
      if (rd_en_b && first_rd_b < 0) first_rd_b = cyc;
      if (tvalid_b && tready) begin
        hs_b.push_back(cyc);
        if (exp_b.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL beat_b_unexpected actual=%0h required=none", tdata_b);
        end else begin
          e = exp_b.pop_front();
          check("beat_b_data", tdata_b, e[31:0]);
          check("beat_b_last", 32'(tlast_b), 32'(e[32]));
        end
      end
    end
  end

  task automatic push_both(input logic [31:0] d);
    pend_a.push_back(d);
    pend_b.push_back(d);
    exp_a.push_back({(beat_a == 3), d});
    beat_a = (beat_a + 1) % 4;
    exp_b.push_back({1'b0, d});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_a.size() + exp_b.size()), 32'd0);
  endtask

  task automatic set_inputs(input logic rst, input logic rdy);
    @(posedge clk);
    #1;
    reset  = rst;
    tready = rdy;
  endtask

  initial begin
    int sa, sb, n;
    bit seen_a, seen_b, done_a, done_b;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_a_rd_en", 32'(rd_en_a), 0);
    check("rst_a_tvalid", 32'(tvalid_a), 0);
    check("rst_a_tlast", 32'(tlast_a), 0);
    check("rst_a_tdata", tdata_a, 0);
    check("rst_a_busy", 32'(busy_a), 0);
    check("rst_a_pkt", 32'(pkt_a), 0);
    check("rst_b_rd_en", 32'(rd_en_b), 0);
    check("rst_b_tvalid", 32'(tvalid_b), 0);
    check("rst_b_tdata", tdata_b, 0);
    check("rst_b_busy", 32'(busy_b), 0);
    set_inputs(1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Streaming 0x10..0x17 with tready held high
    hs_a.delete(); hs_b.delete();
    first_rd_a = -1; first_rd_b = -1;
    sa = strobes_a; sb = strobes_b;
    for (int i = 0; i < 8; i++) push_both(32'h10 + 32'(i));
    drain("t1");
    check("t1_a_strobes", 32'(strobes_a - sa), 8);
    check("t1_b_strobes", 32'(strobes_b - sb), 8);
    check("t1_a_beats", 32'(hs_a.size()), 8);
    check("t1_b_beats", 32'(hs_b.size()), 8);
    if (hs_a.size() == 8) begin
      check("t1_a_latency", 32'(hs_a[0] - first_rd_a), 2);
      for (int i = 1; i < 8; i++) check("t1_a_spacing", 32'(hs_a[i] - hs_a[i-1]), 2);
    end
    if (hs_b.size() == 8) begin
      check("t1_b_latency", 32'(hs_b[0] - first_rd_b), 2);
      for (int i = 1; i < 8; i++) check("t1_b_spacing", 32'(hs_b[i] - hs_b[i-1]), 1);
    end
    check("t1_a_pkt", 32'(pkt_a), 2);
    check("t1_b_pkt", 32'(pkt_b), 0);

    // Backpressure: tready low for 10 cycles with data waiting
    set_inputs(1'b0, 1'b0);
    sa = strobes_a; sb = strobes_b;
    for (int i = 0; i < 8; i++) push_both(32'h10 + 32'(i));
    repeat (10) begin
      @(negedge clk);
      if (tvalid_a) check("t2_a_hold", tdata_a, 32'h10);
      if (tvalid_b) check("t2_b_hold", tdata_b, 32'h10);
    end
    check("t2_a_tvalid", 32'(tvalid_a), 1);
    check("t2_b_tvalid", 32'(tvalid_b), 1);
    check("t2_a_strobes_le_depth", 32'((strobes_a - sa) <= 2), 1);
    check("t2_b_strobes_le_depth", 32'((strobes_b - sb) <= 3), 1);
    set_inputs(1'b0, 1'b1);
    drain("t2");
    check("t2_a_pkt", 32'(pkt_a), 4);

    // Single entry written while empty
    @(negedge clk);
    sa = strobes_a; sb = strobes_b;
    push_both(32'hAB);
    seen_a = 0; seen_b = 0; done_a = 0; done_b = 0; n = 0;
    while (!(done_a && done_b) && n < 30) begin
      @(negedge clk);
      n++;
      if (seen_a && !done_a) begin
        check("t3_a_busy_after_hs", 32'(busy_a), 0);
        done_a = 1;
      end else if (!seen_a && tvalid_a) begin
        check("t3_a_busy_at_hs", 32'(busy_a), 1);
        seen_a = 1;
      end
      if (seen_b && !done_b) begin
        check("t3_b_busy_after_hs", 32'(busy_b), 0);
        done_b = 1;
      end else if (!seen_b && tvalid_b) begin
        check("t3_b_busy_at_hs", 32'(busy_b), 1);
        seen_b = 1;
      end
    end
    check("t3_both_done", 32'(done_a && done_b), 1);
    drain("t3");
    check("t3_a_strobes", 32'(strobes_a - sa), 1);
    check("t3_b_strobes", 32'(strobes_b - sb), 1);
    check("t3_a_pkt", 32'(pkt_a), 4);

    // Reset one cycle after a strobe
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_both(32'h30 + 32'(i));
    n = 0;
    while (!rd_en_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t4_strobe_seen", 32'(rd_en_a), 1);
    set_inputs(1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("t4_a_tvalid", 32'(tvalid_a), 0);
    check("t4_a_busy", 32'(busy_a), 0);
    check("t4_a_rd_en", 32'(rd_en_a), 0);
    check("t4_b_tvalid", 32'(tvalid_b), 0);
    check("t4_b_busy", 32'(busy_b), 0);
    check("t4_a_pkt", 32'(pkt_a), 0);
    exp_a.delete();
    exp_b.delete();
    beat_a = 0;
    set_inputs(1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push_both(32'h40 + 32'(i));
    drain("t4");
    check("t4_a_pkt_after", 32'(pkt_a), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
